sevenseg_mux: RTL and testbench
===============================

SEVENSEG_MUX -- requirements
Module: sevenseg_mux

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter PRESCALE, default 1000, clock cycles per digit slot (>=2).
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load, input, 1, single-cycle strobe capturing value.
REQ-006 SHALL have port value, input, 4*N_DIGITS, hex nibbles, digit 0 in bits [3:0].
REQ-007 SHALL have port lzb, input, 1, leading-zero blanking enable.
REQ-008 SHALL have port blank, input, 1, forces all digit enables off.
REQ-009 SHALL have port seg, output, 7, segments gfedcba, active-high.
REQ-010 SHALL have port dig, output, N_DIGITS, one-hot digit enable, active-high.
REQ-011 SHALL have port pending, output, 1, captured value not yet displayed.
REQ-012 SHALL have port frame, output, 1, one-cycle pulse at frame boundary.

Function
REQ-013 SHALL count prescaler 0..PRESCALE-1 and wrap; the cycle at PRESCALE-1 is a tick.
REQ-014 SHALL advance digit index on each tick, wrapping N_DIGITS-1 -> 0.
REQ-015 SHALL treat a tick with index N_DIGITS-1 as frame boundary and assert frame in the following cycle for exactly one cycle.
REQ-016 SHALL, on load, capture value into shadow register next edge and set pending.
REQ-017 SHALL, at frame boundary, copy shadow into display register and clear pending, unless load occurs in the same cycle.
REQ-018 SHALL, on load coincident with a frame boundary, copy the old shadow to display, capture the new value into shadow, and keep pending set.
REQ-019 SHALL register seg and dig from current index and display register, latency one cycle.
REQ-020 SHALL decode nibbles 0-F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, gfedcba).
REQ-021 SHALL, when lzb=1, blank (dig bit 0, seg 00) digits above the most significant nonzero nibble; digit 0 never blanked.
REQ-022 SHALL, when blank=1, drive dig all-zero and seg 00 one cycle later, while the prescaler and index keep running.
REQ-023 SHALL never assert more than one dig bit in any cycle.
REQ-024 SHALL treat load while pending=1 as overwrite of shadow (last value wins).

Reset
REQ-025 SHALL, while n_reset=0, asynchronously clear prescaler, index, shadow, display, pending, frame, seg, dig.
REQ-026 SHALL, on the first edge after release, start at prescaler 0 and index 0, displaying value 0.
REQ-027 SHALL, on reset asserted mid-frame or mid-load, discard the shadow value and not update the display with it.

Structure
REQ-028 SHALL place the 16-entry glyph table and seg_t (7-bit) typedef in package sevenseg_pkg.
REQ-029 SHALL instantiate one combinational sub-module sevenseg_decode (4-bit nibble -> seg_t) using the package table.
REQ-030 SHALL size prescaler and index counters with $clog2 of their parameters.

Verification (bench: N_DIGITS=4, PRESCALE=4)
REQ-031 SHALL check after reset: dig=0001, seg=3F, pending=0; with lzb=0, digits cycle 0001->0010->0100->1000->0001 every 4 cycles.
REQ-032 SHALL check load value=16'h1A3F: pending=1 until the next frame pulse, then digits 0..3 show 71,4F,77,06.
REQ-033 SHALL check lzb=1 with value=16'h0050: digits 2,3 blanked, digit 1 shows 6D, digit 0 shows 3F; value=0 shows only digit 0 = 3F.
REQ-034 SHALL check load on the frame-boundary cycle: display shows the previous shadow for one frame, the new value after the next boundary, and pending stays 1 until then.
REQ-035 SHALL check blank=1 for 10 cycles: dig=0000 and seg=00 throughout; on release, the index continues from the position it would otherwise have reached.
REQ-036 SHALL check n_reset pulsed low mid-frame after load: all outputs clear immediately and the loaded value is never displayed.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment display multiplexer.
//   seg_t       : 7-bit segment vector, bit order gfedcba, active-high
//   GLYPH_TABLE : hex nibble 0-F to segment pattern
//   SEG_OFF     : all segments dark
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : segment pattern gfedcba, active-high
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = GLYPH_TABLE[nibble];

endmodule

// File: rtl/sevenseg_mux.sv
// Time-multiplexed seven-segment display driver.
// A prescaler divides clk into digit slots; each slot lights one digit.
// New values are staged in a shadow register and only move to the display
// register at a frame boundary, so a frame never shows a mix of two values.
//   clk     : single clock, rising edge
//   n_reset : asynchronous active-low reset
//   load    : one-cycle strobe capturing value into the shadow register
//   value   : 4*N_DIGITS hex nibbles, digit 0 in bits [3:0]
//   lzb     : leading-zero blanking enable
//   blank   : forces all digit enables off
//   seg     : segments gfedcba, active-high, registered
//   dig     : one-hot digit enable, active-high, registered
//   pending : shadow holds a value not yet shown
//   frame   : one-cycle pulse after each frame boundary
module sevenseg_mux
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  lzb,
  input  logic                  blank,
  output seg_t                  seg,
  output logic [N_DIGITS-1:0]   dig,
  output logic                  pending,
  output logic                  frame
);

  localparam int PS_W  = $clog2(PRESCALE);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Position of the most significant nonzero nibble; 0 when all are zero,
  // which keeps digit 0 lit under leading-zero blanking.
  function automatic logic [IDX_W-1:0] lead_digit(input logic [4*N_DIGITS-1:0] v);
    lead_digit = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] != 4'h0) lead_digit = IDX_W'(i);
    end
  endfunction

  logic [PS_W-1:0]       presc_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [4*N_DIGITS-1:0] shadow_p0;
  logic [4*N_DIGITS-1:0] display_p0;
  logic                  tick;
  logic                  boundary;

  logic [3:0]            nib;
  logic [IDX_W-1:0]      msd;
  logic                  show;
  logic [N_DIGITS-1:0]   dig_next;
  seg_t                  glyph;

  seg_t                  seg_p1;
  logic [N_DIGITS-1:0]   dig_p1;

  assign tick     = (presc_p0 == PS_LAST);
  assign boundary = tick && (idx_p0 == IDX_LAST);

  // ---- stage p0: slot timing, shadow/display registers ----
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      presc_p0   <= '0;
      idx_p0     <= '0;
      shadow_p0  <= '0;
      display_p0 <= '0;
      pending    <= 1'b0;
      frame      <= 1'b0;
    end else begin
      presc_p0 <= tick ? '0 : presc_p0 + 1'b1;
      if (tick) idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      frame <= boundary;
      // Display takes the pre-edge shadow, so a coincident load still
      // leaves its value waiting for the following boundary.
      if (boundary) display_p0 <= shadow_p0;
      if (load) begin
        shadow_p0 <= value;
        pending   <= 1'b1;
      end else if (boundary) begin
        pending   <= 1'b0;
      end
    end
  end

  always_comb begin
    nib      = 4'h0;
    dig_next = '0;
    msd      = lead_digit(display_p0);
    show     = !blank && !(lzb && (idx_p0 > msd));
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) nib = display_p0[4*i +: 4];
      dig_next[i] = show && (idx_p0 == IDX_W'(i));
    end
  end

  sevenseg_decode u_decode (
    .nibble (nib),
    .seg    (glyph)
  );

  // ---- stage p1: registered segment and digit drive ----
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      seg_p1 <= SEG_OFF;
      dig_p1 <= '0;
    end else begin
      seg_p1 <= show ? glyph : SEG_OFF;
      dig_p1 <= dig_next;
    end
  end

  assign seg = seg_p1;
  assign dig = dig_p1;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Self-checking bench for sevenseg_mux with N_DIGITS=4, PRESCALE=4.
module tb_sevenseg_mux;

  localparam int N = 4;
  localparam int P = 4;

  logic        clk;
  logic        n_reset;
  logic        load;
  logic [15:0] value;
  logic        lzb;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        pending;
  logic        frame;

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 0;

  sevenseg_mux #(.N_DIGITS(N), .PRESCALE(P)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .load    (load),
    .value   (value),
    .lzb     (lzb),
    .blank   (blank),
    .seg     (seg),
    .dig     (dig),
    .pending (pending),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph_tb [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: time since reset, digit slot and frame position are
  // derived arithmetically from a single cycle count.
  int          m_t;
  logic [15:0] m_shadow, m_disp;
  logic        m_pend, m_frame;
  logic [6:0]  m_seg;
  logic [3:0]  m_dig;
  int          m_d, m_msn;
  bit          m_bnd, m_show;

  always_comb begin
    m_d   = (m_t / P) % N;
    m_bnd = (m_t % (P * N)) == (P * N - 1);
    m_msn = 0;
    for (int i = 0; i < N; i++) if (m_disp[4*i +: 4] != 4'h0) m_msn = i;
    m_show = !blank && !(lzb && (m_d > m_msn));
  end

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_t <= 0; m_shadow <= '0; m_disp <= '0; m_pend <= 1'b0;
      m_frame <= 1'b0; m_seg <= '0; m_dig <= '0;
    end else begin
      m_t     <= m_t + 1;
      m_frame <= m_bnd;
      m_dig   <= m_show ? 4'(1 << m_d) : 4'b0;
      m_seg   <= m_show ? glyph_tb[m_disp[4*m_d +: 4]] : 7'h00;
      if (m_bnd) m_disp <= m_shadow;
      if (load) begin
        m_shadow <= value;
        m_pend   <= 1'b1;
      end else if (m_bnd) begin
        m_pend   <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_dig", {28'b0, dig}, {28'b0, m_dig});
      check("mon_seg", {25'b0, seg}, {25'b0, m_seg});
      check("mon_pending", {31'b0, pending}, {31'b0, m_pend});
      check("mon_frame", {31'b0, frame}, {31'b0, m_frame});
    end
  end

  task automatic wait_frame(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame) found = 1;
    end
    check({name, "_frame_seen"}, {31'b0, found}, 32'd1);
  endtask

  task automatic do_load(input string name, input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check({name, "_pending_set"}, {31'b0, pending}, 32'd1);
  endtask

  // Call on the frame-pulse negedge; returns on the next frame-pulse negedge.
  task automatic sample_frame(input string name, input logic [27:0] segs, input logic [3:0] en);
    for (int j = 0; j < N; j++) begin
      logic [3:0] ed;
      logic [6:0] es;
      ed = en[j] ? 4'(1 << j) : 4'b0;
      es = en[j] ? segs[7*j +: 7] : 7'h00;
      @(negedge clk);
      check($sformatf("%s_dig%0d", name, j), {28'b0, dig}, {28'b0, ed});
      check($sformatf("%s_seg%0d", name, j), {25'b0, seg}, {25'b0, es});
      repeat (P - 1) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] value;
    logic        lzb;
    logic [27:0] segs;
    logic [3:0]  en;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [3:0] seq [4];
    vecs[0] = '{16'h1A3F, 1'b0, {7'h06, 7'h77, 7'h4F, 7'h71}, 4'b1111};
    vecs[1] = '{16'h0050, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0011};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001};
    vecs[3] = '{16'h0050, 1'b0, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b1111};
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    n_reset = 1'b1; load = 1'b0; value = '0; lzb = 1'b0; blank = 1'b0;
    #1 n_reset = 1'b0;
    #1;
    mon_en = 1;
    check("rst_dig", {28'b0, dig}, 32'd0);
    check("rst_seg", {25'b0, seg}, 32'd0);
    check("rst_pending", {31'b0, pending}, 32'd0);
    check("rst_frame", {31'b0, frame}, 32'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;

    // Digit rotation straight out of reset.
    @(negedge clk);
    check("post_rst_dig", {28'b0, dig}, 32'b0001);
    check("post_rst_seg", {25'b0, seg}, 32'h3F);
    check("post_rst_pending", {31'b0, pending}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      repeat (P) @(negedge clk);
      check($sformatf("rotate%0d", k), {28'b0, dig}, {28'b0, seq[k]});
    end

    // Table: load, confirm pending until the frame pulse, then one frame of digits.
    for (int v = 0; v < 4; v++) begin
      lzb = vecs[v].lzb;
      wait_frame($sformatf("vec%0d_pre", v));
      do_load($sformatf("vec%0d", v), vecs[v].value);
      wait_frame($sformatf("vec%0d", v));
      check($sformatf("vec%0d_pending_clr", v), {31'b0, pending}, 32'd0);
      sample_frame($sformatf("vec%0d", v), vecs[v].segs, vecs[v].en);
    end

    // Load coincident with a frame boundary.
    lzb = 1'b0;
    wait_frame("bnd_pre");
    do_load("bnd_a", 16'h4321);
    repeat (P * N - 2) @(negedge clk);
    value = 16'h8765;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("bnd_frame", {31'b0, frame}, 32'd1);
    check("bnd_pending_kept", {31'b0, pending}, 32'd1);
    sample_frame("bnd_old", {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b1111);
    check("bnd_pending_clr", {31'b0, pending}, 32'd0);
    sample_frame("bnd_new", {7'h7F, 7'h07, 7'h7D, 7'h6D}, 4'b1111);

    // Blank for 10 cycles starting right after a boundary.
    check("blank_align_frame", {31'b0, frame}, 32'd1);
    blank = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("blank_dig%0d", c), {28'b0, dig}, 32'd0);
      check($sformatf("blank_seg%0d", c), {25'b0, seg}, 32'd0);
    end
    blank = 1'b0;
    @(negedge clk);
    check("blank_resume_dig", {28'b0, dig}, 32'b0100);

    // Reset mid-frame with a pending load.
    wait_frame("rstm_pre");
    do_load("rstm", 16'h9ABC);
    repeat (3) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("rstm_dig", {28'b0, dig}, 32'd0);
    check("rstm_seg", {25'b0, seg}, 32'd0);
    check("rstm_pending", {31'b0, pending}, 32'd0);
    check("rstm_frame", {31'b0, frame}, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    wait_frame("rstm_post");
    check("rstm_pending_after", {31'b0, pending}, 32'd0);
    sample_frame("rstm_zero", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      if ($urandom_range(0, 499) == 0) begin
        #2 n_reset = 1'b0;
        #1 n_reset = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
